// File: rtl/imem_byte_loader.sv
// Host command engine in front of instruction memory: stages big-endian bytes into
// 32-bit words, writes completed words, reads single bytes back and gates cpu_run.
module imem_byte_loader #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [7:0]  CMD_READ  = 8'd1,
   parameter logic [7:0]  CMD_WRITE = 8'd2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        cmd,
   input  logic              cmd_valid,
   input  logic [ADDR_W-1:0] address,
   input  logic [7:0]        data_in,
   output logic              cmd_done,
   output logic              cmd_err,
   output logic [7:0]        data_out,
   output logic              imem_we,
   output logic              imem_re,
   output logic [ADDR_W-3:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       imem_rdata,
   input  logic              start_signal,
   output logic              cpu_run
);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StRdReq,
      StRdWait,
      StDone,
      StRelease
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic [23:0]       stage_q, stage_d;
   logic              err_q, err_d;
   logic              cmd_done_q, cmd_done_d;
   logic              cmd_err_q, cmd_err_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              imem_we_q, imem_we_d;
   logic              imem_re_q, imem_re_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              cpu_run_q, cpu_run_d;
   logic [1:0]        lane;

   assign lane       = addr_q[1:0];
   assign cmd_done   = cmd_done_q;
   assign cmd_err    = cmd_err_q;
   assign data_out   = data_out_q;
   assign imem_we    = imem_we_q;
   assign imem_re    = imem_re_q;
   assign imem_addr  = addr_q[ADDR_W-1:2];
   assign imem_wdata = imem_wdata_q;
   assign cpu_run    = cpu_run_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      stage_d      = stage_q;
      err_d        = err_q;
      data_out_d   = data_out_q;
      imem_wdata_d = imem_wdata_q;
      cmd_done_d   = 1'b0;
      cmd_err_d    = 1'b0;
      imem_we_d    = 1'b0;
      imem_re_d    = 1'b0;
      cpu_run_d    = start_signal & cpu_run_q;

      unique case (state_q)
         StIdle: begin
            // A command arriving together with start_signal takes priority over run.
            if (cmd_valid) begin
               addr_d = address;
               data_d = data_in;
               if (cpu_run_q || (cmd != CMD_READ && cmd != CMD_WRITE)) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else if (cmd == CMD_WRITE) begin
                  err_d   = 1'b0;
                  state_d = StWr;
               end else begin
                  err_d     = 1'b0;
                  imem_re_d = 1'b1;
                  state_d   = StRdReq;
               end
            end else if (start_signal) begin
               cpu_run_d = 1'b1;
            end
         end
         StWr: begin
            case (lane)
               2'd0: stage_d[23:16] = data_q;
               2'd1: stage_d[15:8]  = data_q;
               2'd2: stage_d[7:0]   = data_q;
               default: begin
                  imem_we_d    = 1'b1;
                  imem_wdata_d = {stage_q, data_q};
                  stage_d      = '0;
               end
            endcase
            state_d = StDone;
         end
         StRdReq: state_d = StRdWait;
         StRdWait: begin
            case (lane)
               2'd0:    data_out_d = imem_rdata[31:24];
               2'd1:    data_out_d = imem_rdata[23:16];
               2'd2:    data_out_d = imem_rdata[15:8];
               default: data_out_d = imem_rdata[7:0];
            endcase
            state_d = StDone;
         end
         StDone: begin
            cmd_done_d = 1'b1;
            cmd_err_d  = err_q;
            state_d    = StRelease;
         end
         StRelease: begin
            if (!cmd_valid) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         data_q       <= '0;
         stage_q      <= '0;
         err_q        <= 1'b0;
         cmd_done_q   <= 1'b0;
         cmd_err_q    <= 1'b0;
         data_out_q   <= '0;
         imem_we_q    <= 1'b0;
         imem_re_q    <= 1'b0;
         imem_wdata_q <= '0;
         cpu_run_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         stage_q      <= stage_d;
         err_q        <= err_d;
         cmd_done_q   <= cmd_done_d;
         cmd_err_q    <= cmd_err_d;
         data_out_q   <= data_out_d;
         imem_we_q    <= imem_we_d;
         imem_re_q    <= imem_re_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_run_q    <= cpu_run_d;
      end
   end

endmodule

// File: tb/tb_imem_byte_loader.sv
// Randomized bench for imem_byte_loader: a word-level memory/staging model predicts
// every command outcome, latency and strobe count.
module tb_imem_byte_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cmd;
   logic        cmd_valid;
   logic [7:0]  address;
   logic [7:0]  data_in;
   logic        cmd_done;
   logic        cmd_err;
   logic [7:0]  data_out;
   logic        imem_we;
   logic        imem_re;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] imem_rdata = '0;
   logic        start_signal;
   logic        cpu_run;

   imem_byte_loader #(
      .ADDR_W   (8),
      .CMD_READ (8'd1),
      .CMD_WRITE(8'd2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .address     (address),
      .data_in     (data_in),
      .cmd_done    (cmd_done),
      .cmd_err     (cmd_err),
      .data_out    (data_out),
      .imem_we     (imem_we),
      .imem_re     (imem_re),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .imem_rdata  (imem_rdata),
      .start_signal(start_signal),
      .cpu_run     (cpu_run)
   );

   always #5 clk = ~clk;

   // Instruction memory with one-cycle synchronous read.
   logic [31:0] mem [64] = '{default: '0};
   always @(posedge clk) begin
      if (imem_we) mem[imem_addr] <= imem_wdata;
      if (imem_re) imem_rdata <= mem[imem_addr];
   end

   // Event monitor, sampled 1 time unit after each rising edge.
   int          cyc = 0, n_done = 0, n_we = 0, n_re = 0;
   int          done_cyc = 0, we_cyc = 0, re_cyc = 0;
   logic        last_err = 1'b0;
   logic [31:0] last_wdata = '0;
   logic [5:0]  last_waddr = '0;
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (cmd_done) begin
         n_done   = n_done + 1;
         done_cyc = cyc;
         last_err = cmd_err;
      end
      if (imem_we) begin
         n_we       = n_we + 1;
         we_cyc     = cyc;
         last_wdata = imem_wdata;
         last_waddr = imem_addr;
      end
      if (imem_re) begin
         n_re   = n_re + 1;
         re_cyc = cyc;
      end
   end

   // Reference model: staged bytes, memory image, run flag, last read byte.
   logic [7:0]  stg [3];
   logic [31:0] ref_mem [64];
   logic        run_exp;
   logic [7:0]  exp_dout;
   int          total = 0, bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_done"}, 32'(cmd_done), 32'd0);
      check_eq({tag, "_err"}, 32'(cmd_err), 32'd0);
      check_eq({tag, "_dout"}, 32'(data_out), 32'd0);
      check_eq({tag, "_we"}, 32'(imem_we), 32'd0);
      check_eq({tag, "_re"}, 32'(imem_re), 32'd0);
      check_eq({tag, "_addr"}, 32'(imem_addr), 32'd0);
      check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
      check_eq({tag, "_run"}, 32'(cpu_run), 32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) stg[i] = 8'd0;
      run_exp  = 1'b0;
      exp_dout = 8'd0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      start_signal = 1'b0;
      cmd_valid    = 1'b0;
      rst          = 1'b1;
      #1;
      check_outputs_zero("rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   task automatic do_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                         input int hold, input logic st);
      int          d0, w0, r0, c0, lane, exp_lat;
      logic        pre_run, exp_err, exp_we, exp_re;
      logic [31:0] word;
      @(negedge clk);
      d0 = n_done; w0 = n_we; r0 = n_re; c0 = cyc;
      pre_run      = run_exp;
      cmd          = c;
      address      = a;
      data_in      = d;
      cmd_valid    = 1'b1;
      start_signal = st;

      lane    = int'(a[1:0]);
      exp_err = pre_run || (c != 8'd1 && c != 8'd2);
      exp_we  = 1'b0;
      exp_re  = !exp_err && c == 8'd1;
      word    = '0;
      if (!exp_err && c == 8'd2) begin
         if (lane == 3) begin
            word = {stg[0], stg[1], stg[2], d};
            ref_mem[a[7:2]] = word;
            for (int i = 0; i < 3; i++) stg[i] = 8'd0;
            exp_we = 1'b1;
         end else begin
            stg[lane] = d;
         end
      end
      if (exp_re) begin
         word     = ref_mem[a[7:2]];
         exp_dout = word[31-8*lane -: 8];
      end
      exp_lat = exp_err ? 2 : (exp_re ? 4 : 3);

      @(negedge clk);
      check_eq("run_at_accept", 32'(cpu_run), 32'(pre_run && st));
      cmd     = 8'($urandom);
      address = 8'($urandom);
      data_in = 8'($urandom);
      if (hold > 1) repeat (hold - 1) @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 12 && n_done == d0; i++) @(negedge clk);
      repeat (3) @(negedge clk);

      check_eq("done_count", 32'(n_done - d0), 32'd1);
      check_eq("err", 32'(last_err), 32'(exp_err));
      check_eq("done_latency", 32'(done_cyc - c0), 32'(exp_lat));
      check_eq("we_count", 32'(n_we - w0), 32'(exp_we));
      if (exp_we) begin
         check_eq("wdata", last_wdata, word);
         check_eq("waddr", 32'(last_waddr), 32'(a[7:2]));
         check_eq("we_latency", 32'(we_cyc - c0), 32'd2);
      end
      check_eq("re_count", 32'(n_re - r0), 32'(exp_re));
      if (exp_re) check_eq("re_latency", 32'(re_cyc - c0), 32'd1);
      check_eq("data_out", 32'(data_out), 32'(exp_dout));
      run_exp = st;
      check_eq("run_after", 32'(cpu_run), 32'(run_exp));
   endtask

   // Reset while a lane-3 write is in WR: no word may reach imem.
   task automatic inflight_reset();
      int d0, w0;
      @(negedge clk);
      d0 = n_done; w0 = n_we;
      cmd = 8'd2; address = 8'h23; data_in = 8'h5A; cmd_valid = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs_zero("inflight_rst");
      @(negedge clk);
      cmd_valid = 1'b0;
      rst       = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      check_eq("inflight_we", 32'(n_we - w0), 32'd0);
      check_eq("inflight_done", 32'(n_done - d0), 32'd0);
   endtask

   initial begin
      logic [7:0] c, a;
      logic       st;
      int         r;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      model_reset();
      rst = 1'b1; cmd = '0; cmd_valid = 1'b0; address = '0; data_in = '0;
      start_signal = 1'b0;
      #2;
      check_outputs_zero("por");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Four byte writes forming one word.
      do_cmd(8'd2, 8'd0, 8'h00, 5, 1'b0);
      do_cmd(8'd2, 8'd1, 8'h50, 5, 1'b0);
      do_cmd(8'd2, 8'd2, 8'h01, 5, 1'b0);
      do_cmd(8'd2, 8'd3, 8'h13, 5, 1'b0);
      check_eq("word0", last_wdata, 32'h0050_0113);
      do_cmd(8'd1, 8'd1, 8'h00, 4, 1'b0);
      check_eq("read_lane1", 32'(data_out), 32'h50);

      // Long hold: one execution only.
      do_cmd(8'd2, 8'd8, 8'h77, 20, 1'b0);

      // Unknown command, then writes rejected while running.
      do_cmd(8'd7, 8'd0, 8'h00, 3, 1'b0);
      @(negedge clk);
      start_signal = 1'b1;
      @(negedge clk);
      check_eq("run_rise", 32'(cpu_run), 32'd1);
      run_exp = 1'b1;
      do_cmd(8'd2, 8'd3, 8'hAA, 3, 1'b1);
      @(negedge clk);
      start_signal = 1'b0;
      @(negedge clk);
      check_eq("run_fall", 32'(cpu_run), 32'd0);
      run_exp = 1'b0;

      // start_signal and a command in the same idle cycle: command first.
      do_cmd(8'd2, 8'd12, 8'h11, 2, 1'b1);
      do_cmd(8'd1, 8'd12, 8'h00, 2, 1'b0);

      // Partial word, reset, then finish the word.
      do_cmd(8'd2, 8'd16, 8'hAA, 3, 1'b0);
      do_cmd(8'd2, 8'd17, 8'hBB, 3, 1'b0);
      pulse_reset();
      do_cmd(8'd2, 8'd18, 8'h01, 3, 1'b0);
      do_cmd(8'd2, 8'd19, 8'h13, 3, 1'b0);
      check_eq("word4", last_wdata, 32'h0000_0113);
      inflight_reset();

      for (int n = 0; n < 150; n++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 5)      c = 8'd2;
         else if (r <= 8) c = 8'd1;
         else             c = 8'($urandom_range(3, 255));
         a  = 8'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
         st = ($urandom_range(0, 5) == 0) ? ~run_exp : run_exp;
         do_cmd(c, a, 8'($urandom), int'($urandom_range(1, 6)), st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
